// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: memory-op codes, FSM states and
// small op-classification helpers used by both the FSM and the lane logic.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LH   = 4'd2,
    MEM_OP_LW   = 4'd3,
    MEM_OP_LD   = 4'd4,
    MEM_OP_LBU  = 4'd5,
    MEM_OP_LHU  = 4'd6,
    MEM_OP_LWU  = 4'd7,
    MEM_OP_SB   = 4'd8,
    MEM_OP_SH   = 4'd9,
    MEM_OP_SW   = 4'd10,
    MEM_OP_SD   = 4'd11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_LWU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= MEM_OP_SB) && (op <= MEM_OP_SD);
  endfunction

  // log2 of the access size in bytes; codes outside the table behave as NONE
  function automatic logic [1:0] op_size_log2(input logic [3:0] op);
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2'd1;
      MEM_OP_LW, MEM_OP_LWU, MEM_OP_SW: return 2'd2;
      MEM_OP_LD, MEM_OP_SD:             return 2'd3;
      default:                          return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: alignment check, write mask and data shift for
// requests, and right-shift plus sign/zero extension for load responses.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  i_req_op,
  input  logic [2:0]  i_req_off,
  input  logic [63:0] i_req_wdata,
  input  logic [3:0]  i_rsp_op,
  input  logic [2:0]  i_rsp_off,
  input  logic [63:0] i_rsp_rdata,
  output logic        o_misalign,
  output logic [7:0]  o_wmask,
  output logic [63:0] o_wdata,
  output logic [63:0] o_load_data
);

  logic [1:0]  w_req_size;
  logic [7:0]  w_lanes;
  logic [63:0] w_rsp_shifted;

  always_comb begin
    w_req_size = op_size_log2(i_req_op);
    case (w_req_size)
      2'd0:    w_lanes = 8'h01;
      2'd1:    w_lanes = 8'h03;
      2'd2:    w_lanes = 8'h0F;
      default: w_lanes = 8'hFF;
    endcase

    case (w_req_size)
      2'd1:    o_misalign = i_req_off[0];
      2'd2:    o_misalign = |i_req_off[1:0];
      2'd3:    o_misalign = |i_req_off;
      default: o_misalign = 1'b0;
    endcase

    o_wmask = op_is_store(i_req_op) ? (w_lanes << i_req_off) : 8'h00;
    o_wdata = i_req_wdata << {i_req_off, 3'b000};

    w_rsp_shifted = i_rsp_rdata >> {i_rsp_off, 3'b000};
    case (i_rsp_op)
      MEM_OP_LB:  o_load_data = {{56{w_rsp_shifted[7]}},  w_rsp_shifted[7:0]};
      MEM_OP_LH:  o_load_data = {{48{w_rsp_shifted[15]}}, w_rsp_shifted[15:0]};
      MEM_OP_LW:  o_load_data = {{32{w_rsp_shifted[31]}}, w_rsp_shifted[31:0]};
      MEM_OP_LBU: o_load_data = {56'd0, w_rsp_shifted[7:0]};
      MEM_OP_LHU: o_load_data = {48'd0, w_rsp_shifted[15:0]};
      MEM_OP_LWU: o_load_data = {32'd0, w_rsp_shifted[31:0]};
      default:    o_load_data = w_rsp_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: accepts one op from execute, performs an optional
// data-memory access, and holds the result until write-back takes it.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [3:0]  ex_mem_op,
  input  logic [63:0] ex_addr,
  input  logic [63:0] ex_wdata,
  input  logic [63:0] ex_alu_result,
  input  logic        ex_rd_w_ena,
  input  logic [4:0]  ex_rd_w_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_rd_w_ena,
  output logic [4:0]  wb_rd_w_addr,
  output logic [63:0] wb_rd_data,
  output logic        wb_misalign
);

  state_e      r_state, w_state_next;
  logic [3:0]  r_op;
  logic [2:0]  r_off;
  logic [63:0] r_mem_addr, r_mem_wdata, r_rd_data;
  logic [7:0]  r_mem_wmask;
  logic        r_mem_we, r_rd_w_ena, r_misalign;
  logic [4:0]  r_rd_w_addr;

  logic        w_accept, w_is_mem, w_go_busy, w_misalign;
  logic [7:0]  w_wmask;
  logic [63:0] w_wdata, w_load_data;

  mem_align u_align (
    .i_req_op    (ex_mem_op),
    .i_req_off   (ex_addr[2:0]),
    .i_req_wdata (ex_wdata),
    .i_rsp_op    (r_op),
    .i_rsp_off   (r_off),
    .i_rsp_rdata (mem_rdata),
    .o_misalign  (w_misalign),
    .o_wmask     (w_wmask),
    .o_wdata     (w_wdata),
    .o_load_data (w_load_data)
  );

  assign ex_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & wb_ready);
  assign w_accept  = ex_valid & ex_ready;
  assign w_is_mem  = op_is_load(ex_mem_op) | op_is_store(ex_mem_op);
  assign w_go_busy = w_is_mem & ~w_misalign;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = w_go_busy ? ST_BUSY : ST_DONE;
      ST_BUSY: if (mem_ack) w_state_next = ST_DONE;
      ST_DONE: begin
        if (wb_ready) begin
          if (w_accept) w_state_next = w_go_busy ? ST_BUSY : ST_DONE;
          else          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= 4'd0;
      r_off       <= 3'd0;
      r_mem_addr  <= 64'd0;
      r_mem_wdata <= 64'd0;
      r_mem_wmask <= 8'd0;
      r_mem_we    <= 1'b0;
      r_rd_w_ena  <= 1'b0;
      r_rd_w_addr <= 5'd0;
      r_rd_data   <= 64'd0;
      r_misalign  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op        <= ex_mem_op;
        r_off       <= ex_addr[2:0];
        r_mem_addr  <= {ex_addr[63:3], 3'b000};
        r_mem_we    <= op_is_store(ex_mem_op);
        r_mem_wmask <= w_wmask;
        r_mem_wdata <= w_wdata;
        r_rd_w_addr <= ex_rd_w_addr;
        r_rd_w_ena  <= ex_rd_w_ena & (ex_rd_w_addr != 5'd0)
                       & ~op_is_store(ex_mem_op) & ~w_misalign;
        r_misalign  <= w_misalign;
        r_rd_data   <= w_is_mem ? 64'd0 : ex_alu_result;
      end else if ((r_state == ST_BUSY) && mem_ack && op_is_load(r_op)) begin
        r_rd_data <= w_load_data;
      end
    end
  end

  // Request fields come straight from registers, so they are stable across BUSY
  assign mem_req      = (r_state == ST_BUSY);
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_wmask    = r_mem_wmask;
  assign wb_valid     = (r_state == ST_DONE);
  assign wb_rd_w_ena  = r_rd_w_ena;
  assign wb_rd_w_addr = r_rd_w_addr;
  assign wb_rd_data   = r_rd_data;
  assign wb_misalign  = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, randomized transactions
// checked against a byte-level reference model, and reset/back-to-back sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_rd_w_ena;
  logic [3:0]  ex_mem_op;
  logic [63:0] ex_addr, ex_wdata, ex_alu_result;
  logic [4:0]  ex_rd_w_addr;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        wb_valid, wb_ready, wb_rd_w_ena, wb_misalign;
  logic [4:0]  wb_rd_w_addr;
  logic [63:0] wb_rd_data;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_op(ex_mem_op),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_alu_result(ex_alu_result),
    .ex_rd_w_ena(ex_rd_w_ena), .ex_rd_w_addr(ex_rd_w_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_w_ena(wb_rd_w_ena),
    .wb_rd_w_addr(wb_rd_w_addr), .wb_rd_data(wb_rd_data), .wb_misalign(wb_misalign)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] addr, wdata, alu, rdata;
    logic        rd_ena;
    logic [4:0]  rd;
    int          ack_dly, wb_dly;
  } txn_t;

  typedef struct {
    logic        req, we, rd_ena, mis;
    logic [63:0] maddr, mwdata, data;
    logic [7:0]  wmask;
  } exp_t;

  typedef struct {
    txn_t t;
    exp_t e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_st(input logic [3:0] op);
    return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW, MEM_OP_SD};
  endfunction

  // Reference: works byte by byte on the 8-byte memory word
  function automatic exp_t model(input txn_t t);
    exp_t e;
    int   size, off;
    bit   sgn, ld;
    size = 0; sgn = 0;
    case (t.op)
      MEM_OP_LB:  begin size = 1; sgn = 1; end
      MEM_OP_LH:  begin size = 2; sgn = 1; end
      MEM_OP_LW:  begin size = 4; sgn = 1; end
      MEM_OP_LD:  begin size = 8; sgn = 1; end
      MEM_OP_LBU, MEM_OP_SB: size = 1;
      MEM_OP_LHU, MEM_OP_SH: size = 2;
      MEM_OP_LWU, MEM_OP_SW: size = 4;
      MEM_OP_SD:             size = 8;
      default:               size = 0;
    endcase
    ld = (size != 0) && !is_st(t.op);
    off = int'(t.addr[2:0]);
    e.req = 0; e.we = 0; e.rd_ena = 0; e.mis = 0;
    e.maddr = 0; e.mwdata = 0; e.data = 0; e.wmask = 0;
    if (size == 0) begin
      e.data   = t.alu;
      e.rd_ena = t.rd_ena && (t.rd != 0);
    end else if ((off % size) != 0) begin
      e.mis = 1;
    end else begin
      e.req   = 1;
      e.maddr = t.addr - 64'(off);
      e.we    = is_st(t.op);
      if (e.we) begin
        for (int i = 0; i < size; i++) e.wmask[off + i] = 1'b1;
        e.mwdata = t.wdata << (8 * off);
      end else begin
        for (int i = 0; i < size; i++) e.data[8*i +: 8] = t.rdata[8*(off+i) +: 8];
        if (sgn && e.data[8*size-1])
          for (int b = 8 * size; b < 64; b++) e.data[b] = 1'b1;
      end
      e.rd_ena = ld && t.rd_ena && (t.rd != 0);
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [63:0] addr, wdata, alu,
                              input logic rd_ena, input logic [4:0] rd, input logic [63:0] rdata,
                              input int ack, wbd, input logic req, input logic [63:0] maddr,
                              input logic we, input logic [7:0] wmask, input logic [63:0] mwdata,
                              input logic [63:0] data, input logic rden, input logic mis);
    vec_t v;
    v.t.op = op; v.t.addr = addr; v.t.wdata = wdata; v.t.alu = alu; v.t.rd_ena = rd_ena;
    v.t.rd = rd; v.t.rdata = rdata; v.t.ack_dly = ack; v.t.wb_dly = wbd;
    v.e.req = req; v.e.maddr = maddr; v.e.we = we; v.e.wmask = wmask; v.e.mwdata = mwdata;
    v.e.data = data; v.e.rd_ena = rden; v.e.mis = mis;
    return v;
  endfunction

  task automatic drive_garbage();
    ex_mem_op     = 4'($urandom_range(0, 11));
    ex_addr       = {$urandom, $urandom};
    ex_wdata      = {$urandom, $urandom};
    ex_alu_result = {$urandom, $urandom};
    ex_rd_w_ena   = 1'($urandom);
    ex_rd_w_addr  = 5'($urandom);
  endtask

  // Runs one op from IDLE to IDLE; ex_valid stays high with junk while ex_ready=0
  task automatic do_txn(input txn_t t, input exp_t e, input string nm);
    ex_valid = 1; ex_mem_op = t.op; ex_addr = t.addr; ex_wdata = t.wdata;
    ex_alu_result = t.alu; ex_rd_w_ena = t.rd_ena; ex_rd_w_addr = t.rd; wb_ready = 0;
    #1;
    chk({nm, " ex_ready_idle"}, 64'(ex_ready), 64'd1);
    step();
    drive_garbage();
    #1;
    if (e.req) begin
      for (int k = 0; k < t.ack_dly; k++) begin
        chk({nm, " mem_req"}, 64'(mem_req), 64'd1);
        chk({nm, " mem_addr"}, mem_addr, e.maddr);
        chk({nm, " mem_we"}, 64'(mem_we), 64'(e.we));
        chk({nm, " mem_wmask"}, 64'(mem_wmask), 64'(e.wmask));
        if (e.we) chk({nm, " mem_wdata"}, mem_wdata, e.mwdata);
        chk({nm, " ex_ready_busy"}, 64'(ex_ready), 64'd0);
        chk({nm, " wb_valid_busy"}, 64'(wb_valid), 64'd0);
        if (k == t.ack_dly - 1) begin
          mem_ack = 1; mem_rdata = t.rdata;
        end
        step();
        mem_ack = 0; mem_rdata = {$urandom, $urandom};
        #1;
      end
    end else begin
      chk({nm, " no_mem_req"}, 64'(mem_req), 64'd0);
    end
    for (int k = 0; k <= t.wb_dly; k++) begin
      if (k == t.wb_dly) begin
        ex_valid = 0; wb_ready = 1;
      end
      #1;
      chk({nm, " wb_valid"}, 64'(wb_valid), 64'd1);
      chk({nm, " mem_req_done"}, 64'(mem_req), 64'd0);
      chk({nm, " wb_misalign"}, 64'(wb_misalign), 64'(e.mis));
      chk({nm, " wb_rd_w_ena"}, 64'(wb_rd_w_ena), 64'(e.rd_ena));
      chk({nm, " wb_rd_w_addr"}, 64'(wb_rd_w_addr), 64'(t.rd));
      if (!is_st(t.op) && !e.mis) chk({nm, " wb_rd_data"}, wb_rd_data, e.data);
      chk({nm, " ex_ready_done"}, 64'(ex_ready), (k == t.wb_dly) ? 64'd1 : 64'd0);
      step();
    end
    wb_ready = 0;
    #1;
    chk({nm, " wb_valid_after"}, 64'(wb_valid), 64'd0);
    chk({nm, " ex_ready_after"}, 64'(ex_ready), 64'd1);
    $display("txn %s op=%0d addr=%h wb_data=%h mis=%0b", nm, t.op, t.addr, wb_rd_data, wb_misalign);
  endtask

  vec_t vecs[17];
  txn_t rt;

  initial begin
    rst = 1; ex_valid = 0; ex_mem_op = 0; ex_addr = 0; ex_wdata = 0; ex_alu_result = 0;
    ex_rd_w_ena = 0; ex_rd_w_addr = 0; mem_ack = 0; mem_rdata = 0; wb_ready = 0;

    vecs[0]  = mk(MEM_OP_NONE, 64'h0, 64'h0, 64'h1234, 1, 5, 64'h0, 1, 0, 0, 64'h0, 0, 8'h00, 64'h0, 64'h1234, 1, 0);
    vecs[1]  = mk(MEM_OP_LB, 64'h1003, 64'h0, 64'h0, 1, 7, 64'h80000000, 3, 1, 1, 64'h1000, 0, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFF80, 1, 0);
    vecs[2]  = mk(MEM_OP_LBU, 64'h1003, 64'h0, 64'h0, 1, 7, 64'h80000000, 3, 0, 1, 64'h1000, 0, 8'h00, 64'h0, 64'h80, 1, 0);
    vecs[3]  = mk(MEM_OP_SH, 64'h2006, 64'hBEEF, 64'h0, 1, 3, 64'h0, 1, 0, 1, 64'h2000, 1, 8'hC0, 64'hBEEF0000_00000000, 64'h0, 0, 0);
    vecs[4]  = mk(MEM_OP_LW, 64'h3002, 64'h0, 64'h0, 1, 6, 64'h0, 1, 0, 0, 64'h0, 0, 8'h00, 64'h0, 64'h0, 0, 1);
    vecs[5]  = mk(MEM_OP_LD, 64'h4008, 64'h0, 64'h0, 1, 9, 64'h81234567_89ABCDEF, 2, 2, 1, 64'h4008, 0, 8'h00, 64'h0, 64'h81234567_89ABCDEF, 1, 0);
    vecs[6]  = mk(MEM_OP_LH, 64'h5006, 64'h0, 64'h0, 1, 10, 64'h80010000_00000000, 1, 0, 1, 64'h5000, 0, 8'h00, 64'h0, 64'hFFFFFFFF_FFFF8001, 1, 0);
    vecs[7]  = mk(MEM_OP_LHU, 64'h5006, 64'h0, 64'h0, 1, 11, 64'h80010000_00000000, 1, 0, 1, 64'h5000, 0, 8'h00, 64'h0, 64'h8001, 1, 0);
    vecs[8]  = mk(MEM_OP_LW, 64'h5004, 64'h0, 64'h0, 1, 12, 64'h89ABCDEF_00000000, 2, 0, 1, 64'h5000, 0, 8'h00, 64'h0, 64'hFFFFFFFF_89ABCDEF, 1, 0);
    vecs[9]  = mk(MEM_OP_LWU, 64'h5004, 64'h0, 64'h0, 1, 13, 64'h89ABCDEF_00000000, 1, 0, 1, 64'h5000, 0, 8'h00, 64'h0, 64'h89ABCDEF, 1, 0);
    vecs[10] = mk(MEM_OP_SD, 64'h6000, 64'h01020304_05060708, 64'h0, 1, 2, 64'h0, 1, 0, 1, 64'h6000, 1, 8'hFF, 64'h01020304_05060708, 64'h0, 0, 0);
    vecs[11] = mk(MEM_OP_SB, 64'h6005, 64'hAA, 64'h0, 1, 2, 64'h0, 2, 0, 1, 64'h6000, 1, 8'h20, 64'h0000AA00_00000000, 64'h0, 0, 0);
    vecs[12] = mk(MEM_OP_SW, 64'h6004, 64'h11223344, 64'h0, 0, 2, 64'h0, 1, 1, 1, 64'h6000, 1, 8'hF0, 64'h11223344_00000000, 64'h0, 0, 0);
    vecs[13] = mk(MEM_OP_LD, 64'h7004, 64'h0, 64'h0, 1, 4, 64'h0, 1, 0, 0, 64'h0, 0, 8'h00, 64'h0, 64'h0, 0, 1);
    vecs[14] = mk(MEM_OP_NONE, 64'h0, 64'h0, 64'hDEAD, 1, 0, 64'h0, 1, 4, 0, 64'h0, 0, 8'h00, 64'h0, 64'hDEAD, 0, 0);
    vecs[15] = mk(MEM_OP_LH, 64'h0001, 64'h0, 64'h0, 1, 4, 64'h0, 1, 0, 0, 64'h0, 0, 8'h00, 64'h0, 64'h0, 0, 1);
    vecs[16] = mk(MEM_OP_LB, 64'h0010, 64'h0, 64'h0, 0, 8, 64'h55, 1, 0, 1, 64'h0010, 0, 8'h00, 64'h0, 64'h55, 0, 0);

    step(); step();
    rst = 0;
    #1;
    chk("rst ex_ready", 64'(ex_ready), 64'd1);
    chk("rst mem_req", 64'(mem_req), 64'd0);
    chk("rst wb_valid", 64'(wb_valid), 64'd0);
    chk("rst mem_addr", mem_addr, 64'd0);
    chk("rst mem_wmask", 64'(mem_wmask), 64'd0);
    chk("rst wb_rd_data", wb_rd_data, 64'd0);
    chk("rst wb_rd_w_ena", 64'(wb_rd_w_ena), 64'd0);

    // Stray ack while IDLE must not create a result
    mem_ack = 1; step(); mem_ack = 0; #1;
    chk("idle_ack wb_valid", 64'(wb_valid), 64'd0);

    for (int i = 0; i < 17; i++) do_txn(vecs[i].t, vecs[i].e, $sformatf("vec%0d", i));

    for (int i = 0; i < 60; i++) begin
      rt.op = 4'($urandom_range(0, 11));
      rt.addr = {$urandom, $urandom}; rt.wdata = {$urandom, $urandom};
      rt.alu = {$urandom, $urandom}; rt.rdata = {$urandom, $urandom};
      rt.rd_ena = 1'($urandom); rt.rd = 5'($urandom);
      if ($urandom_range(0, 1) == 0) rt.addr[2:0] = 3'd0;
      rt.ack_dly = $urandom_range(1, 3); rt.wb_dly = $urandom_range(0, 2);
      do_txn(rt, model(rt), $sformatf("rnd%0d", i));
    end

    // Back-to-back: held result, then next ops accepted without a bubble
    ex_valid = 1; ex_mem_op = MEM_OP_NONE; ex_alu_result = 64'hA1; ex_rd_w_ena = 1; ex_rd_w_addr = 4;
    step();
    ex_alu_result = 64'hB2; ex_rd_w_addr = 6;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("b2b hold wb_valid", 64'(wb_valid), 64'd1);
      chk("b2b hold wb_rd_data", wb_rd_data, 64'hA1);
      chk("b2b hold ex_ready", 64'(ex_ready), 64'd0);
      step();
    end
    wb_ready = 1; #1;
    chk("b2b ex_ready", 64'(ex_ready), 64'd1);
    chk("b2b first data", wb_rd_data, 64'hA1);
    step();
    chk("b2b second valid", 64'(wb_valid), 64'd1);
    chk("b2b second data", wb_rd_data, 64'hB2);
    chk("b2b second rd", 64'(wb_rd_w_addr), 64'd6);
    ex_mem_op = MEM_OP_LD; ex_addr = 64'h8000; ex_rd_w_addr = 7;
    step();
    ex_valid = 0; wb_ready = 0; #1;
    chk("b2b mem_req", 64'(mem_req), 64'd1);
    chk("b2b mem_addr", mem_addr, 64'h8000);
    mem_ack = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    step(); mem_ack = 0; #1;
    chk("b2b ld data", wb_rd_data, 64'h0123_4567_89AB_CDEF);
    wb_ready = 1; step(); wb_ready = 0; #1;
    chk("b2b idle", 64'(wb_valid), 64'd0);
    $display("txn b2b sequence done");

    // Reset while BUSY, with a late ack
    ex_valid = 1; ex_mem_op = MEM_OP_LD; ex_addr = 64'h9000; ex_rd_w_addr = 3;
    step(); ex_valid = 0; #1;
    chk("rstbusy mem_req_before", 64'(mem_req), 64'd1);
    rst = 1; step(); rst = 0; #1;
    chk("rstbusy mem_req", 64'(mem_req), 64'd0);
    chk("rstbusy mem_addr", mem_addr, 64'd0);
    chk("rstbusy ex_ready", 64'(ex_ready), 64'd1);
    chk("rstbusy wb_valid", 64'(wb_valid), 64'd0);
    step();
    mem_ack = 1; mem_rdata = 64'hFFFF; step(); mem_ack = 0; #1;
    chk("rstbusy late_ack wb_valid", 64'(wb_valid), 64'd0);
    chk("rstbusy late_ack mem_req", 64'(mem_req), 64'd0);
    step();
    chk("rstbusy later wb_valid", 64'(wb_valid), 64'd0);
    $display("txn reset-in-busy sequence done");

    // Reset while DONE discards the held result
    ex_valid = 1; ex_mem_op = MEM_OP_NONE; ex_alu_result = 64'h77; ex_rd_w_ena = 1; ex_rd_w_addr = 9;
    step(); ex_valid = 0; #1;
    chk("rstdone held", 64'(wb_valid), 64'd1);
    rst = 1; step(); rst = 0; #1;
    chk("rstdone wb_valid", 64'(wb_valid), 64'd0);
    chk("rstdone wb_rd_w_ena", 64'(wb_rd_w_ena), 64'd0);
    chk("rstdone wb_rd_data", wb_rd_data, 64'd0);
    chk("rstdone ex_ready", 64'(ex_ready), 64'd1);
    $display("txn reset-in-done sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
